// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code conversion arbiter: code width, FSM states and a
// reference conversion function.
package gray_pkg;

  localparam int unsigned CODE_W = 4;

  typedef enum logic [0:0] {ST_IDLE, ST_FULL} conv_state_t;

  function automatic logic [3:0] bin2gray_f(input logic [3:0] b);
    return {b[3], b[3] ^ b[2], b[2] ^ b[1], b[1] ^ b[0]};
  endfunction

endpackage

// File: rtl/bin2gray.sv
// Purely combinational 4-bit binary to Gray code converter.
module bin2gray
  import gray_pkg::*;
(
  input  logic [CODE_W-1:0] bin,
  output logic [CODE_W-1:0] gray
);

  assign gray = {bin[3], bin[3] ^ bin[2], bin[2] ^ bin[1], bin[1] ^ bin[0]};

endmodule

// File: rtl/gray_conv_arbiter.sv
// Shares one bin2gray converter among NUM_REQ requesters with round-robin arbitration and a
// single registered result stage that accepts one conversion per cycle.
module gray_conv_arbiter
  import gray_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [CODE_W*NUM_REQ-1:0]  req_bin,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CODE_W-1:0]          out_gray,
  output logic [CODE_W-1:0]          out_bin,
  output logic [ID_W-1:0]            out_id,
  output logic [7:0]                 conv_cnt
);

  conv_state_t       state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q;
  logic [ID_W-1:0]   winner;
  logic              found;
  logic              can_accept;
  logic              accept;
  logic [CODE_W-1:0] win_bin;
  logic [CODE_W-1:0] win_gray;
  int                idx;

  // Search starts at rr_ptr and wraps at NUM_REQ, so IDs >= NUM_REQ never win.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      idx = (int'(rr_ptr_q) + k) % int'(NUM_REQ);
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  assign can_accept = (state_q == ST_IDLE) | out_ready;
  assign accept     = found & can_accept;
  assign req_ready  = accept ? (NUM_REQ'(1) << winner) : '0;
  assign win_bin    = req_bin[int'(winner)*CODE_W +: CODE_W];
  assign out_valid  = (state_q == ST_FULL);

  bin2gray u_bin2gray (
    .bin  (win_bin),
    .gray (win_gray)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_FULL;
      ST_FULL: if (out_ready && !accept) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      out_gray <= '0;
      out_bin  <= '0;
      out_id   <= '0;
      conv_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        out_gray <= win_gray;
        out_bin  <= win_bin;
        out_id   <= winner;
        rr_ptr_q <= ID_W'((int'(winner) + 1) % int'(NUM_REQ));
      end
      if (out_valid && out_ready) conv_cnt <= conv_cnt + 8'd1;
    end
  end

endmodule
